swarm_run_ctrl: RTL and testbench

Host-side run sequencer between the host control/load interface and the solver core grid. It opens a load window, gates the broadcast CNF stream into all cores, and pulses the common start. It then watches every core's done/sat/unsat, latches the first reported result with the winning core index, and enforces an optional cycle timeout. It replaces the direct host-to-grid wiring with an explicit, observable state machine.

---
 rtl/satswarmv2_pkg.sv | 19 +
 rtl/swarm_run_ctrl_first_done_pick.sv | 37 +++
 rtl/swarm_run_ctrl.sv | 177 +++++++++++++++++
 tb/tb_swarm_run_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/satswarmv2_pkg.sv
// satswarmv2_pkg: shared run-state encoding and core-index width for the swarm run sequencer.
// rev 1.0
`default_nettype none

package satswarmv2_pkg;

  localparam int RUN_CORE_ID_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } run_state_e;

endpackage

`default_nettype wire

// File: rtl/swarm_run_ctrl_first_done_pick.sv
// first_done_pick: lowest-index priority encoder over per-core done flags.
// rev 1.0
`default_nettype none

module first_done_pick
  import satswarmv2_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0]     done,
  input  logic [NUM_CORES-1:0]     sat,
  input  logic [NUM_CORES-1:0]     unsat,
  output logic                     any,
  output logic [RUN_CORE_ID_W-1:0] idx,
  output logic                     pick_sat,
  output logic                     pick_unsat
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    any        = 1'b0;
    idx        = '0;
    pick_sat   = 1'b0;
    pick_unsat = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (done[i]) begin
        any        = 1'b1;
        idx        = RUN_CORE_ID_W'(i);
        pick_sat   = sat[i];
        pick_unsat = unsat[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/swarm_run_ctrl.sv
// swarm_run_ctrl: host-side load/start/result sequencer for the solver core grid.
// rev 1.0
`default_nettype none

module swarm_run_ctrl
  import satswarmv2_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_W = 32,
  parameter int CNT_W     = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_load_begin,
  input  logic                     cmd_start,
  input  logic                     cmd_abort,
  input  logic [TIMEOUT_W-1:0]     cfg_timeout_cycles,
  input  logic                     host_load_valid,
  input  logic signed [31:0]       host_load_literal,
  input  logic                     host_load_clause_end,
  output logic                     host_load_ready,
  output logic                     core_load_valid,
  output logic [31:0]              core_load_literal,
  output logic                     core_load_clause_end,
  input  logic [NUM_CORES-1:0]     core_load_ready,
  output logic                     core_start,
  output logic                     core_abort,
  input  logic [NUM_CORES-1:0]     core_done,
  input  logic [NUM_CORES-1:0]     core_sat,
  input  logic [NUM_CORES-1:0]     core_unsat,
  output logic [2:0]               state,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     result_sat,
  output logic                     result_unsat,
  output logic                     result_timeout,
  output logic                     result_conflict,
  output logic [RUN_CORE_ID_W-1:0] result_core_id,
  output logic [TIMEOUT_W-1:0]     run_cycles,
  output logic [CNT_W-1:0]         lit_count,
  output logic [CNT_W-1:0]         clause_count
);

  run_state_e             cur;
  logic [TIMEOUT_W-1:0]   limit;
  logic                   pick_any;
  logic [RUN_CORE_ID_W-1:0] pick_idx;
  logic                   pick_sat;
  logic                   pick_unsat;
  logic                   start_ok;
  logic                   load_open;
  logic                   beat;
  logic                   go_load;
  logic                   go_arm;
  logic                   abort_act;

  first_done_pick #(.NUM_CORES(NUM_CORES)) u_pick (
    .done       (core_done),
    .sat        (core_sat),
    .unsat      (core_unsat),
    .any        (pick_any),
    .idx        (pick_idx),
    .pick_sat   (pick_sat),
    .pick_unsat (pick_unsat)
  );

  assign start_ok  = cmd_start & (clause_count != '0);
  // The window closes in any cycle that leaves or restarts LOAD so no beat is lost to a clear.
  assign load_open = (cur == ST_LOAD) & ~cmd_abort & ~start_ok & ~cmd_load_begin;

  assign host_load_ready      = load_open & (&core_load_ready);
  assign core_load_valid      = host_load_valid & load_open;
  assign core_load_literal    = host_load_literal;
  assign core_load_clause_end = host_load_clause_end;
  assign beat                 = host_load_valid & host_load_ready;

  assign abort_act = cmd_abort & (cur != ST_IDLE);
  assign state     = cur;

  always_comb begin
    go_load = 1'b0;
    go_arm  = 1'b0;
    case (cur)
      ST_IDLE: go_load = cmd_load_begin & ~cmd_abort;
      ST_LOAD: begin
        go_arm  = start_ok & ~cmd_abort;
        go_load = cmd_load_begin & ~cmd_abort & ~start_ok;
      end
      ST_DONE: begin
        go_arm  = cmd_start & ~cmd_abort;
        go_load = cmd_load_begin & ~cmd_abort & ~cmd_start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur             <= ST_IDLE;
      busy            <= 1'b0;
      core_start      <= 1'b0;
      core_abort      <= 1'b0;
      limit           <= '0;
      result_valid    <= 1'b0;
      result_sat      <= 1'b0;
      result_unsat    <= 1'b0;
      result_timeout  <= 1'b0;
      result_conflict <= 1'b0;
      result_core_id  <= '0;
      run_cycles      <= '0;
      lit_count       <= '0;
      clause_count    <= '0;
    end else begin
      core_start <= go_arm;
      core_abort <= abort_act;

      if (beat) begin
        if (lit_count != '1) lit_count <= lit_count + CNT_W'(1);
        if (host_load_clause_end && clause_count != '1) clause_count <= clause_count + CNT_W'(1);
      end
      if (abort_act || go_load) begin
        lit_count    <= '0;
        clause_count <= '0;
      end
      if (abort_act || go_load || go_arm) begin
        result_valid    <= 1'b0;
        result_sat      <= 1'b0;
        result_unsat    <= 1'b0;
        result_timeout  <= 1'b0;
        result_conflict <= 1'b0;
        result_core_id  <= '0;
        run_cycles      <= '0;
      end
      if (go_arm) limit <= cfg_timeout_cycles;

      if (abort_act) begin
        cur  <= ST_IDLE;
        busy <= 1'b0;
      end else if (go_load) begin
        cur  <= ST_LOAD;
        busy <= 1'b1;
      end else if (go_arm) begin
        cur  <= ST_ARM;
        busy <= 1'b1;
      end else begin
        case (cur)
          ST_ARM: begin
            cur        <= ST_RUN;
            run_cycles <= '0;
          end
          ST_RUN: begin
            if (run_cycles != '1) run_cycles <= run_cycles + TIMEOUT_W'(1);
            if (pick_any) begin
              cur             <= ST_DONE;
              busy            <= 1'b0;
              result_valid    <= 1'b1;
              result_sat      <= pick_sat;
              result_unsat    <= pick_unsat;
              result_conflict <= pick_sat & pick_unsat;
              result_core_id  <= pick_idx;
            end else if (limit != '0 && run_cycles == limit - TIMEOUT_W'(1)) begin
              cur            <= ST_DONE;
              busy           <= 1'b0;
              result_valid   <= 1'b1;
              result_timeout <= 1'b1;
              result_core_id <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_swarm_run_ctrl.sv
// tb_swarm_run_ctrl: directed self-checking bench for swarm_run_ctrl.
// rev 1.0
`default_nettype none

module tb_swarm_run_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_load_begin = 1'b0;
  logic               cmd_start = 1'b0;
  logic               cmd_abort = 1'b0;
  logic [31:0]        cfg_timeout_cycles = '0;
  logic               host_load_valid = 1'b0;
  logic signed [31:0] host_load_literal = '0;
  logic               host_load_clause_end = 1'b0;
  logic               host_load_ready;
  logic               core_load_valid;
  logic [31:0]        core_load_literal;
  logic               core_load_clause_end;
  logic [3:0]         core_load_ready = 4'hF;
  logic               core_start;
  logic               core_abort;
  logic [3:0]         core_done = '0;
  logic [3:0]         core_sat = '0;
  logic [3:0]         core_unsat = '0;
  logic [2:0]         state;
  logic               busy;
  logic               result_valid;
  logic               result_sat;
  logic               result_unsat;
  logic               result_timeout;
  logic               result_conflict;
  logic [3:0]         result_core_id;
  logic [31:0]        run_cycles;
  logic [23:0]        lit_count;
  logic [23:0]        clause_count;

  int vectors = 0;
  int miscompares = 0;

  swarm_run_ctrl #(.NUM_CORES(4), .TIMEOUT_W(32), .CNT_W(24)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cmd_load_begin       (cmd_load_begin),
    .cmd_start            (cmd_start),
    .cmd_abort            (cmd_abort),
    .cfg_timeout_cycles   (cfg_timeout_cycles),
    .host_load_valid      (host_load_valid),
    .host_load_literal    (host_load_literal),
    .host_load_clause_end (host_load_clause_end),
    .host_load_ready      (host_load_ready),
    .core_load_valid      (core_load_valid),
    .core_load_literal    (core_load_literal),
    .core_load_clause_end (core_load_clause_end),
    .core_load_ready      (core_load_ready),
    .core_start           (core_start),
    .core_abort           (core_abort),
    .core_done            (core_done),
    .core_sat             (core_sat),
    .core_unsat           (core_unsat),
    .state                (state),
    .busy                 (busy),
    .result_valid         (result_valid),
    .result_sat           (result_sat),
    .result_unsat         (result_unsat),
    .result_timeout       (result_timeout),
    .result_conflict      (result_conflict),
    .result_core_id       (result_core_id),
    .run_cycles           (run_cycles),
    .lit_count            (lit_count),
    .clause_count         (clause_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load_begin();
    cmd_load_begin = 1'b1;
    tick();
    cmd_load_begin = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", state); end
    vectors++; if ({busy, result_valid, core_start, core_abort, result_timeout} !== 5'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 00000", {busy, result_valid, core_start, core_abort, result_timeout}); end
    vectors++; if ({lit_count, clause_count} !== 48'd0 || run_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_counts: got lit %0d cl %0d rc %0d want 0", lit_count, clause_count, run_cycles); end
    vectors++; if (host_load_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", host_load_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    int lits[6] = '{1, -2, 3, 4, -5, 6};
    bit ends[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    pulse_load_begin();
    vectors++; if (state !== 3'd1 || busy !== 1'b1) begin miscompares++; $display("FAIL load_enter: got state %0d busy %b want 1 1", state, busy); end
    for (int i = 0; i < 6; i++) begin
      host_load_valid      = 1'b1;
      host_load_literal    = lits[i];
      host_load_clause_end = ends[i];
      if (i == 2) begin
        core_load_ready = 4'b1101;
        #1;
        vectors++; if (host_load_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", host_load_ready); end
        tick();
        tick();
        vectors++; if (lit_count !== 24'd2) begin miscompares++; $display("FAIL stall_count: got %0d want 2", lit_count); end
        core_load_ready = 4'hF;
      end
      #1;
      vectors++; if (core_load_valid !== 1'b1 || core_load_literal !== 32'(lits[i]) || host_load_ready !== 1'b1) begin miscompares++; $display("FAIL pass_through beat %0d: got v%b lit %0d rdy %b want 1 %0d 1", i, core_load_valid, $signed(core_load_literal), host_load_ready, lits[i]); end
      tick();
      if (i == 3) begin
        vectors++; if (lit_count !== 24'd4 || clause_count !== 24'd2) begin miscompares++; $display("FAIL mid_counts: got lit %0d cl %0d want 4 2", lit_count, clause_count); end
      end
    end
    host_load_valid      = 1'b0;
    host_load_clause_end = 1'b0;
    #1;
    vectors++; if (lit_count !== 24'd6 || clause_count !== 24'd3) begin miscompares++; $display("FAIL load_counts: got lit %0d cl %0d want 6 3", lit_count, clause_count); end
  endtask

  task automatic test_start_result();
    pulse_start();
    vectors++; if (core_start !== 1'b1 || state !== 3'd2) begin miscompares++; $display("FAIL start_pulse: got cs %b state %0d want 1 2", core_start, state); end
    tick();
    vectors++; if (core_start !== 1'b0 || state !== 3'd3 || run_cycles !== 32'd0) begin miscompares++; $display("FAIL start_once: got cs %b state %0d rc %0d want 0 3 0", core_start, state, run_cycles); end
    repeat (9) tick();
    vectors++; if (run_cycles !== 32'd9) begin miscompares++; $display("FAIL run_count: got %0d want 9", run_cycles); end
    core_done = 4'b0100;
    core_sat  = 4'b0100;
    tick();
    core_done = '0;
    core_sat  = '0;
    vectors++; if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b1100 || result_core_id !== 4'd2) begin miscompares++; $display("FAIL first_result: got vsut %b id %0d want 1100 2", {result_valid, result_sat, result_unsat, result_timeout}, result_core_id); end
    vectors++; if (run_cycles !== 32'd10 || state !== 3'd4 || busy !== 1'b0) begin miscompares++; $display("FAIL done_state: got rc %0d state %0d busy %b want 10 4 0", run_cycles, state, busy); end
  endtask

  task automatic test_simultaneous_done();
    pulse_start();
    vectors++; if (result_valid !== 1'b0 || state !== 3'd2) begin miscompares++; $display("FAIL rerun_clear: got rv %b state %0d want 0 2", result_valid, state); end
    tick();
    core_done  = 4'b1010;
    core_sat   = 4'b1000;
    core_unsat = 4'b0010;
    tick();
    core_done  = '0;
    core_sat   = '0;
    core_unsat = '0;
    vectors++; if (result_core_id !== 4'd1 || {result_valid, result_sat, result_unsat, result_conflict} !== 4'b1010) begin miscompares++; $display("FAIL simul_done: got id %0d vsuc %b want 1 1010", result_core_id, {result_valid, result_sat, result_unsat, result_conflict}); end
    pulse_start();
    tick();
    core_done  = 4'b0001;
    core_sat   = 4'b0001;
    core_unsat = 4'b0001;
    tick();
    core_done  = '0;
    core_sat   = '0;
    core_unsat = '0;
    vectors++; if (result_conflict !== 1'b1 || result_core_id !== 4'd0) begin miscompares++; $display("FAIL conflict: got c %b id %0d want 1 0", result_conflict, result_core_id); end
  endtask

  task automatic test_timeout();
    int k;
    bit seen;
    cfg_timeout_cycles = 32'd5;
    pulse_start();
    seen = 1'b0;
    k = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      tick();
      if (result_timeout === 1'b1) begin seen = 1'b1; k = n; end
    end
    vectors++; if (!seen || k != 6) begin miscompares++; $display("FAIL timeout_latency: got %0d cycles (seen %b) want 6", k, seen); end
    vectors++; if (result_valid !== 1'b1 || result_core_id !== 4'd0 || result_sat !== 1'b0 || run_cycles !== 32'd5) begin miscompares++; $display("FAIL timeout_fields: got rv %b id %0d sat %b rc %0d want 1 0 0 5", result_valid, result_core_id, result_sat, run_cycles); end
    pulse_start();
    tick();
    repeat (4) tick();
    core_done = 4'b0001;
    core_sat  = 4'b0001;
    tick();
    core_done = '0;
    core_sat  = '0;
    vectors++; if ({result_valid, result_timeout, result_sat} !== 3'b101) begin miscompares++; $display("FAIL done_beats_timeout: got v/t/s %b want 101", {result_valid, result_timeout, result_sat}); end
    cfg_timeout_cycles = '0;
  endtask

  task automatic test_abort();
    pulse_start();
    tick();
    repeat (3) tick();
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    vectors++; if (core_abort !== 1'b1 || state !== 3'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL abort_run: got ca %b state %0d busy %b want 1 0 0", core_abort, state, busy); end
    vectors++; if ({result_valid, result_sat, result_unsat, result_timeout} !== 4'b0 || run_cycles !== 32'd0 || lit_count !== 24'd0 || clause_count !== 24'd0) begin miscompares++; $display("FAIL abort_clear: got r %b rc %0d lit %0d cl %0d want 0", {result_valid, result_sat, result_unsat, result_timeout}, run_cycles, lit_count, clause_count); end
    tick();
    vectors++; if (core_abort !== 1'b0) begin miscompares++; $display("FAIL abort_once: got %b want 0", core_abort); end
    pulse_load_begin();
    host_load_valid      = 1'b1;
    host_load_literal    = 7;
    host_load_clause_end = 1'b1;
    tick();
    host_load_valid      = 1'b0;
    host_load_clause_end = 1'b0;
    cmd_abort = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_abort = 1'b0;
    cmd_start = 1'b0;
    vectors++; if (state !== 3'd0 || core_start !== 1'b0 || core_abort !== 1'b1) begin miscompares++; $display("FAIL abort_over_start: got state %0d cs %b ca %b want 0 0 1", state, core_start, core_abort); end
  endtask

  task automatic test_illegal_start_reset();
    tick();
    pulse_start();
    vectors++; if (state !== 3'd0 || core_start !== 1'b0) begin miscompares++; $display("FAIL start_in_idle: got state %0d cs %b want 0 0", state, core_start); end
    pulse_load_begin();
    pulse_start();
    vectors++; if (state !== 3'd1 || core_start !== 1'b0) begin miscompares++; $display("FAIL start_empty: got state %0d cs %b want 1 0", state, core_start); end
    host_load_valid      = 1'b1;
    host_load_literal    = -3;
    host_load_clause_end = 1'b1;
    tick();
    cmd_start = 1'b1;
    #1;
    vectors++; if (host_load_ready !== 1'b0 || core_load_valid !== 1'b0) begin miscompares++; $display("FAIL exit_beat_blocked: got rdy %b v %b want 0 0", host_load_ready, core_load_valid); end
    tick();
    cmd_start            = 1'b0;
    host_load_valid      = 1'b0;
    host_load_clause_end = 1'b0;
    vectors++; if (state !== 3'd2 || lit_count !== 24'd1 || clause_count !== 24'd1) begin miscompares++; $display("FAIL exit_counts: got state %0d lit %0d cl %0d want 2 1 1", state, lit_count, clause_count); end
    tick();
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (state !== 3'd0 || busy !== 1'b0 || run_cycles !== 32'd0 || lit_count !== 24'd0 || core_abort !== 1'b0) begin miscompares++; $display("FAIL reset_in_run: got state %0d busy %b rc %0d lit %0d ca %b want 0", state, busy, run_cycles, lit_count, core_abort); end
    tick();
    vectors++; if (core_abort !== 1'b0 || result_valid !== 1'b0) begin miscompares++; $display("FAIL reset_no_abort: got ca %b rv %b want 0 0", core_abort, result_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load();
    test_start_result();
    test_simultaneous_done();
    test_timeout();
    test_abort();
    test_illegal_start_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
